// File: rtl/key_input_conditioner.sv
// Push-button front end: two-flop synchroniser, time-based debounce, active-high level and strobes.
// Define KEY_AUTOREPEAT_EN to add hold-to-repeat press strobes on held keys.
module key_input_conditioner #(
  parameter int unsigned N_KEYS         = 4,
  parameter bit          KEY_ACTIVE_LOW = 1'b1,
  parameter int unsigned STABLE_CYCLES  = 500000,
  parameter int unsigned HOLD_CYCLES    = 25000000,
  parameter int unsigned REPEAT_CYCLES  = 5000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  localparam int unsigned       CntW    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0]   CntLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [N_KEYS-1:0] RawIdle = {N_KEYS{KEY_ACTIVE_LOW}};

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned     HoldMax    = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES
                                                                         : REPEAT_CYCLES;
  localparam int unsigned     HoldW      = $clog2(HoldMax + 1);
  localparam logic [HoldW-1:0] HoldLast   = HoldW'(HOLD_CYCLES - 1);
  localparam logic [HoldW-1:0] RepeatLast = HoldW'(REPEAT_CYCLES - 1);
`endif

  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [N_KEYS-1:0] pressed_sync;

  // Sync stages reset to the not-pressed pin level so no spurious press follows reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RawIdle;
      sync2_q <= RawIdle;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_sync = sync2_q ^ RawIdle;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, press_q, release_q;
    logic            flip, rpt;

    always_comb begin
      flip  = 1'b0;
      cnt_d = cnt_q;
      if (pressed_sync[i] == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntLast) begin
        flip  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

`ifdef KEY_AUTOREPEAT_EN
    logic [HoldW-1:0] hold_q, hold_d;
    logic             rep_q, rep_d;

    // rep_q selects the repeat interval once the initial hold interval has elapsed.
    always_comb begin
      hold_d = hold_q;
      rep_d  = rep_q;
      rpt    = 1'b0;
      if (!level_q || flip) begin
        hold_d = '0;
        rep_d  = 1'b0;
      end else if (hold_q == (rep_q ? RepeatLast : HoldLast)) begin
        rpt    = 1'b1;
        hold_d = '0;
        rep_d  = 1'b1;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        hold_q <= '0;
        rep_q  <= 1'b0;
      end else begin
        hold_q <= hold_d;
        rep_q  <= rep_d;
      end
    end
`else
    assign rpt = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        level_q   <= level_q ^ flip;
        press_q   <= (flip & ~level_q) | rpt;
        release_q <= flip & level_q;
      end
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
  end

endmodule

// File: tb/tb_key_input_conditioner.sv
// Scoreboard bench for key_input_conditioner: stimulus books expected strobes per clock edge,
// a negedge monitor pops and compares them against the DUT every cycle.
module tb_key_input_conditioner;

  localparam int unsigned NK      = 4;
  localparam int unsigned STABLE  = 4;
  localparam int unsigned HOLD    = 10;
  localparam int unsigned REPEAT  = 3;
  localparam int          HORIZON = 200;
  localparam int          LAT     = STABLE + 2;  // from negedge stimulus to flip edge number

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NK-1:0] key_raw = 4'hF;
  logic [NK-1:0] key_level, key_press, key_release;

  key_input_conditioner #(
    .N_KEYS        (NK),
    .KEY_ACTIVE_LOW(1'b1),
    .STABLE_CYCLES (STABLE),
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REPEAT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_raw    (key_raw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [NK-1:0] exp_press [int];
  logic [NK-1:0] exp_fall  [int];
  logic [NK-1:0] raw_cur = 4'hF;
  logic [NK-1:0] mlevel  = '0;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h, want %h", name, cyc, act, req);
    end
  endtask

  task automatic add_press(input int e, input logic [NK-1:0] m);
    if (exp_press.exists(e)) exp_press[e] = exp_press[e] | m;
    else exp_press[e] = m;
  endtask

  task automatic add_fall(input int e, input logic [NK-1:0] m);
    if (exp_fall.exists(e)) exp_fall[e] = exp_fall[e] | m;
    else exp_fall[e] = m;
  endtask

  // Press strobes booked for keys that become pressed at edge e (plus repeats when enabled).
  task automatic book_rise(input int e, input logic [NK-1:0] rise);
    add_press(e, rise);
`ifdef KEY_AUTOREPEAT_EN
    for (int t = e + int'(HOLD); t < e + HORIZON; t += int'(REPEAT)) add_press(t, rise);
`endif
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Stable key change; caller guarantees the previous change has already settled.
  task automatic set_keys(input logic [NK-1:0] raw);
    logic [NK-1:0] po, pn, rise, fall;
    int e;
    po = ~raw_cur;
    pn = ~raw;
    rise = pn & ~po;
    fall = po & ~pn;
    e = cyc + LAT;
    key_raw = raw;
    raw_cur = raw;
    foreach (exp_press[k]) if (k >= e) exp_press[k] = exp_press[k] & ~fall;
    if (rise != '0) book_rise(e, rise);
    if (fall != '0) add_fall(e, fall);
  endtask

  // Short pulses on the raw pins that must never reach the outputs.
  task automatic glitch(input logic [NK-1:0] raw, input int n);
    key_raw = raw;
    step(n);
    key_raw = raw_cur;
  endtask

  task automatic apply_reset(input int hold);
    int ks[$];
    reset_n = 1'b0;
    foreach (exp_press[k]) if (k > cyc) ks.push_back(k);
    foreach (ks[i]) exp_press.delete(ks[i]);
    ks.delete();
    foreach (exp_fall[k]) if (k > cyc) ks.push_back(k);
    foreach (ks[i]) exp_fall.delete(ks[i]);
    #1;
    check("reset_async_clear", {key_level, key_press, key_release}, 12'h000);
    step(hold);
    reset_n = 1'b1;
    book_rise(cyc + LAT, ~raw_cur);
  endtask

  always @(negedge clk) begin
    logic [NK-1:0] ep, ef;
    if (!reset_n) begin
      mlevel = '0;
      check("outputs_in_reset", {key_level, key_press, key_release}, 12'h000);
    end else begin
      ep = '0;
      ef = '0;
      if (exp_press.exists(cyc)) begin
        ep = exp_press[cyc];
        exp_press.delete(cyc);
      end
      if (exp_fall.exists(cyc)) begin
        ef = exp_fall[cyc];
        exp_fall.delete(cyc);
      end
      mlevel = (mlevel | ep) & ~ef;
      check("level_press_release", {key_level, key_press, key_release}, {mlevel, ep, ef});
    end
  end

  initial begin
    int l;
    #2;
    check("reset_state", {key_level, key_press, key_release}, 12'h000);
    step(3);
    reset_n = 1'b1;
    step(4);

    // Clean press on key 0.
    set_keys(4'b1110);
    step(8);
    check("level_after_press0", {8'h00, key_level}, 12'h001);

    // Bounce on key 1: runs of STABLE-1 samples must be rejected.
    glitch(4'b1100, 3);
    glitch(4'b1110, 1);
    glitch(4'b1100, 3);
    glitch(4'b1110, 1);
    check("level_after_bounce", {8'h00, key_level}, 12'h001);
    set_keys(4'b1100);
    step(8);
    check("level_after_press1", {8'h00, key_level}, 12'h003);

    // Releases.
    set_keys(4'b1101);
    step(8);
    check("level_after_release0", {8'h00, key_level}, 12'h002);
    set_keys(4'b1111);
    step(8);
    check("level_idle", {8'h00, key_level}, 12'h000);

    // Simultaneous press and release on keys 1 and 3.
    set_keys(4'b0101);
    step(8);
    check("level_simultaneous", {8'h00, key_level}, 12'h00A);
    set_keys(4'b1111);
    step(8);

    // Reset mid-count with keys held: both re-register after release.
    set_keys(4'b0111);
    step(8);
    check("level_key3", {8'h00, key_level}, 12'h008);
    set_keys(4'b0011);
    step(2);
    apply_reset(2);
    step(8);
    check("level_after_reset", {8'h00, key_level}, 12'h00C);
    set_keys(4'b1111);
    step(8);

    // Long hold on key 0: repeat strobes appear only with auto-repeat enabled.
    l = cyc + LAT;
    set_keys(4'b1110);
    while (cyc < l + 12) step(1);
    set_keys(4'b1111);
    step(10);
    check("level_final", {8'h00, key_level}, 12'h000);
    check("scoreboard_drained", 12'(exp_press.num() + exp_fall.num()), 12'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
